// File: rtl/uart_tx_rr_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ clients.
// It captures the winner's byte and parity config and fires a single DATA_VALID pulse.
// It then follows TX BUSY up and back down, and finally acks the winner.
module uart_tx_rr_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]            REQ_PAR_EN,
  input  logic [NUM_REQ-1:0]            REQ_PAR_TYP,
  output logic [NUM_REQ-1:0]            REQ_ACK,
  output logic [NUM_REQ-1:0]            GRANT,
  output logic [DATA_WIDTH-1:0]         TX_P_DATA,
  output logic                          TX_DATA_VALID,
  output logic                          TX_PAR_EN,
  output logic                          TX_PAR_TYP,
  input  logic                          TX_BUSY,
  output logic                          TIMEOUT_ERR,
  output logic                          ARB_IDLE
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BUSY_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_WAIT_DONE, S_ACK
  } state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           last_q, last_d;
  logic [IW-1:0]           win_q, win_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    par_en_q, par_en_d;
  logic                    par_typ_q, par_typ_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  logic                    pick_found;
  logic [IW-1:0]           pick_idx;
  logic [IW-1:0]           cand;

  // Round-robin search: first requester set starting one past the last winner.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IW'((int'(last_q) + off) % NUM_REQ);
      if (!pick_found && REQ_VALID[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state and captured-frame logic; TX_* registers hold their value unless a new grant happens.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    win_d     = win_q;
    grant_d   = grant_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    cnt_d     = '0;
    case (state_q)
      S_IDLE: begin
        // A busy TX here belongs to someone else (or a frame that outlived a reset): hold off.
        if (pick_found && !TX_BUSY) begin
          win_d     = pick_idx;
          grant_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
          data_d    = REQ_DATA[pick_idx*DATA_WIDTH +: DATA_WIDTH];
          par_en_d  = REQ_PAR_EN[pick_idx];
          par_typ_d = REQ_PAR_TYP[pick_idx];
          state_d   = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        if (TX_BUSY) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CNT_MAX) begin
          // TX never picked the byte up: give up, but still advance the pointer.
          grant_d = '0;
          last_d  = win_q;
          state_d = S_IDLE;
        end
      end
      S_WAIT_DONE: if (!TX_BUSY) state_d = S_ACK;
      S_ACK: begin
        grant_d = '0;
        last_d  = win_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset; pointer starts at NUM_REQ-1 so requester 0 goes first.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      last_q    <= IW'(NUM_REQ - 1);
      win_q     <= '0;
      grant_q   <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      win_q     <= win_d;
      grant_q   <= grant_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      cnt_q     <= cnt_d;
    end
  end

  assign GRANT         = grant_q;
  assign TX_P_DATA     = data_q;
  assign TX_PAR_EN     = par_en_q;
  assign TX_PAR_TYP    = par_typ_q;
  assign TX_DATA_VALID = (state_q == S_LAUNCH);
  assign REQ_ACK       = (state_q == S_ACK) ? grant_q : '0;
  assign TIMEOUT_ERR   = (state_q == S_WAIT_BUSY) && !TX_BUSY && (cnt_q == CNT_MAX);
  assign ARB_IDLE      = (state_q == S_IDLE);

endmodule

// File: tb/tb_uart_tx_rr_arbiter.sv
// Bench for uart_tx_rr_arbiter: directed scenarios followed by randomized request traffic.
// A simple UART TX stand-in raises BUSY 2 cycles after DATA_VALID and holds it for 11 cycles.
module tb_uart_tx_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_pe = '0;
  logic [3:0]  req_pt = '0;
  logic [3:0]  req_ack, grant;
  logic [7:0]  tx_data;
  logic        dv, tx_pe, tx_pt, tx_busy, terr, aidle;

  uart_tx_rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BUSY_TIMEOUT(16)) dut (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_DATA(req_data),
    .REQ_PAR_EN(req_pe), .REQ_PAR_TYP(req_pt), .REQ_ACK(req_ack), .GRANT(grant),
    .TX_P_DATA(tx_data), .TX_DATA_VALID(dv), .TX_PAR_EN(tx_pe), .TX_PAR_TYP(tx_pt),
    .TX_BUSY(tx_busy), .TIMEOUT_ERR(terr), .ARB_IDLE(aidle)
  );

  always #5 clk = ~clk;

  // TX stand-in: not reset by the arbiter's reset, like the real transmitter.
  bit tx_en = 1'b1;
  bit force_busy = 1'b0;
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (tx_en && dv) busy_cnt <= 12;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = force_busy | (busy_cnt >= 1 && busy_cnt <= 11);

  // Reference model state: what each requester is presenting, and the last winner.
  logic [7:0] m_data [4];
  bit         m_pe [4];
  bit         m_pt [4];
  int         last_m = 3;
  int         checks = 0;
  int         errors = 0;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input bit pe, input bit pt);
    req_valid[i] = 1'b1;
    req_data[i*8 +: 8] = d;
    req_pe[i] = pe;
    req_pt[i] = pt;
    m_data[i] = d;
    m_pe[i] = pe;
    m_pt[i] = pt;
  endtask

  task automatic rnd_req(input int i);
    set_req(i, 8'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Round-robin rule: first valid requester at last+1, last+2, ... modulo 4.
  function automatic int pick(input logic [3:0] v);
    for (int o = 1; o <= 4; o++) begin
      int j;
      j = (last_m + o) % 4;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic wait_dv(input int max, output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!dv && lat < max);
    chk("dv_seen", dv, 1);
  endtask

  // One full frame for winner w; returns in the ACK cycle so the caller can update requests.
  task automatic frame(input int w, input int exp_lat, input bit scramble, input bit drop);
    int lat, n, extra;
    logic [7:0] ed;
    bit epe, ept;
    ed = m_data[w]; epe = m_pe[w]; ept = m_pt[w];
    wait_dv(60, lat);
    if (exp_lat > 0) chk("dv_latency", lat, exp_lat);
    chk("grant", grant, 32'(1) << w);
    chk("tx_data", tx_data, ed);
    chk("tx_par_en", tx_pe, epe);
    chk("tx_par_typ", tx_pt, ept);
    chk("not_idle", aidle, 0);
    if (scramble) set_req(w, 8'($urandom), 1'($urandom), 1'($urandom));
    if (drop) req_valid[w] = 1'b0;
    n = 0; extra = 0;
    do begin
      step();
      n++;
      if (dv) extra++;
    end while (req_ack == 4'd0 && n < 60);
    chk("ack", req_ack, 32'(1) << w);
    chk("ack_latency", n, 14);
    chk("ack_grant", grant, 32'(1) << w);
    chk("held_data", tx_data, ed);
    chk("held_par", {tx_pe, tx_pt}, {epe, ept});
    chk("single_dv", extra, 0);
    last_m = w;
  endtask

  task automatic post_ack();
    step();
    chk("ack_one_cycle", req_ack, 0);
    chk("grant_cleared", grant, 0);
    chk("idle_after_ack", aidle, 1);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ack", req_ack, 0);
    chk("rst_grant", grant, 0);
    chk("rst_dv", dv, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_par", {tx_pe, tx_pt}, 0);
    chk("rst_terr", terr, 0);
    chk("rst_idle", aidle, 1);
  endtask

  initial begin
    int lat, cnt, w;
    // Reset state
    step(); step();
    chk_reset_outputs();

    // Single requester 1 with parity enabled, even
    rst = 1'b0;
    set_req(1, 8'hA9, 1'b1, 1'b0);
    frame(1, 1, 1'b0, 1'b0);
    req_valid = '0;
    post_ack();

    // All four held: reset pointer so order is 0,1,2,3,0
    rst = 1'b1; step(); rst = 1'b0; last_m = 3;
    for (int i = 0; i < 4; i++) rnd_req(i);
    for (int k = 0; k < 5; k++) begin
      frame(k % 4, 1, 1'b0, 1'b0);
      if (k < 4) rnd_req(k % 4);
      else begin req_valid[0] = 1'b0; req_valid[1] = 1'b0; end
      post_ack();
    end
    // Requester 2 next, then 1001 must go 3 before 0
    frame(2, 1, 1'b0, 1'b0);
    req_valid[2] = 1'b0;
    rnd_req(0);
    post_ack();
    frame(3, 1, 1'b0, 1'b0);
    req_valid[3] = 1'b0;
    post_ack();
    frame(0, 1, 1'b0, 1'b0);
    req_valid[0] = 1'b0;
    post_ack();

    // TX never goes busy: timeout pulse 16 cycles after WAIT_BUSY entry
    tx_en = 1'b0;
    set_req(0, 8'h5C, 1'b0, 1'b1);
    wait_dv(60, lat);
    chk("to_dv_latency", lat, 1);
    step();
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (terr || req_ack != 4'd0 || dv) cnt++;
    end
    chk("to_quiet_before", cnt, 0);
    step();
    chk("to_pulse", terr, 1);
    chk("to_no_ack", req_ack, 0);
    req_valid[0] = 1'b0;
    last_m = 0;
    step();
    chk("to_pulse_once", terr, 0);
    chk("to_grant_clr", grant, 0);
    chk("to_idle", aidle, 1);
    tx_en = 1'b1;

    // Foreign BUSY blocks launch; launch the cycle after it falls
    force_busy = 1'b1;
    rnd_req(2);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (dv || grant != 4'd0 || !aidle) cnt++;
    end
    chk("busy_blocks", cnt, 0);
    force_busy = 1'b0;
    frame(2, 1, 1'b0, 1'b0);
    req_valid[2] = 1'b0;
    post_ack();

    // Reset during WAIT_DONE
    rnd_req(1);
    wait_dv(60, lat);
    chk("r6_grant", grant, 4'b0010);
    for (int i = 0; i < 5; i++) step();
    chk("r6_hold", grant, 4'b0010);
    rst = 1'b1;
    req_valid[1] = 1'b0;
    step();
    chk_reset_outputs();
    rst = 1'b0;
    last_m = 3;
    rnd_req(0); rnd_req(3);
    frame(0, 0, 1'b0, 1'b0);
    req_valid[0] = 1'b0;
    post_ack();
    frame(3, 1, 1'b0, 1'b0);
    req_valid[3] = 1'b0;
    post_ack();

    // Randomized traffic against the round-robin model
    rnd_req($urandom_range(3, 0));
    for (int k = 0; k < 40; k++) begin
      w = pick(req_valid);
      frame(w, 1, 1'($urandom), ($urandom_range(3, 0) == 0));
      for (int i = 0; i < 4; i++) begin
        if (i == w) begin
          if ($urandom_range(1, 0) == 1) rnd_req(i);
          else req_valid[i] = 1'b0;
        end else if (!req_valid[i] && $urandom_range(2, 0) == 0) begin
          rnd_req(i);
        end
      end
      if (req_valid == 4'd0) rnd_req($urandom_range(3, 0));
      post_ack();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
